// File: rtl/adc_framer_pkg.sv
// Shared types and helpers for the ADC burst framer: header magic,
// state encoding and header word construction.
package adc_framer_pkg;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } framer_state_e;

  function automatic logic [31:0] build_header(input logic [7:0]  frame_idx,
                                               input logic [15:0] burst_idx);
    return {HDR_MAGIC, frame_idx, burst_idx};
  endfunction

endpackage

// File: rtl/adc_burst_framer.sv
// Pulls fixed-length bursts of ADC word pairs from the capture FIFO and
// emits them downstream as a contiguous header-prefixed stream.
module adc_burst_framer
  import adc_framer_pkg::*;
#(
  parameter int BURST_LEN = 256,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [15:0]      frame_bursts,
  output logic             fifo_rd_en,
  input  logic [31:0]      fifo_dout,
  input  logic             fifo_valid,
  input  logic [CNT_W-1:0] fifo_count,
  input  logic [CNT_W-1:0] sink_space,
  output logic [31:0]      out_data,
  output logic             out_valid,
  output logic             out_hdr,
  output logic             frame_done,
  output logic             busy,
  output logic             err_underflow
);

  localparam int RC_W = $clog2(BURST_LEN);
  localparam logic [RC_W-1:0]  LAST_RD   = RC_W'(BURST_LEN - 1);
  localparam logic [CNT_W:0]   FIFO_NEED = (CNT_W + 1)'(BURST_LEN);
  localparam logic [CNT_W:0]   SINK_NEED = (CNT_W + 1)'(BURST_LEN + 1);

  framer_state_e   state_q, state_d;
  logic [RC_W-1:0] rd_cnt_q, rd_cnt_d;
  logic            expected_q;
  logic [31:0]     out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            out_hdr_q, out_hdr_d;
  logic [15:0]     burst_idx_q, burst_idx_d;
  logic [7:0]      frame_idx_q, frame_idx_d;
  logic            frame_wrap_q, frame_wrap_d;
  logic            frame_done_q;
  logic            err_q, err_d;

  logic            start_ok;
  logic            hdr_load;
  logic [15:0]     last_burst;

  assign start_ok   = enable
                    && ({1'b0, fifo_count} >= FIFO_NEED)
                    && ({1'b0, sink_space} >= SINK_NEED);
  assign last_burst = (frame_bursts == 16'd0) ? 16'd0 : frame_bursts - 16'd1;
  // First READ cycle: no read is in flight yet, so the output slot is free for the header.
  assign hdr_load   = (state_q == READ) && (rd_cnt_q == '0);

  always_comb begin
    state_d      = state_q;
    rd_cnt_d     = rd_cnt_q;
    burst_idx_d  = burst_idx_q;
    frame_idx_d  = frame_idx_q;
    frame_wrap_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d  = READ;
          rd_cnt_d = '0;
        end
      end
      READ: begin
        if (rd_cnt_q == LAST_RD) begin
          state_d = DRAIN;
        end else begin
          rd_cnt_d = rd_cnt_q + RC_W'(1);
        end
      end
      DRAIN: begin
        state_d = IDLE;
        if (burst_idx_q == last_burst) begin
          burst_idx_d  = 16'd0;
          frame_idx_d  = frame_idx_q + 8'd1;
          frame_wrap_d = 1'b1;
        end else begin
          burst_idx_d = burst_idx_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_hdr_d   = hdr_load;
    out_valid_d = hdr_load | (expected_q & fifo_valid);
    out_data_d  = hdr_load ? build_header(frame_idx_q, burst_idx_q) : fifo_dout;
    err_d       = err_q | (expected_q & ~fifo_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rd_cnt_q     <= '0;
      expected_q   <= 1'b0;
      out_data_q   <= 32'd0;
      out_valid_q  <= 1'b0;
      out_hdr_q    <= 1'b0;
      burst_idx_q  <= 16'd0;
      frame_idx_q  <= 8'd0;
      frame_wrap_q <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_cnt_q     <= rd_cnt_d;
      expected_q   <= fifo_rd_en;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_hdr_q    <= out_hdr_d;
      burst_idx_q  <= burst_idx_d;
      frame_idx_q  <= frame_idx_d;
      // Delayed one extra cycle so the pulse lands after the last data word leaves.
      frame_wrap_q <= frame_wrap_d;
      frame_done_q <= frame_wrap_q;
      err_q        <= err_d;
    end
  end

  assign fifo_rd_en    = (state_q == READ);
  assign busy          = (state_q != IDLE);
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_hdr       = out_hdr_q;
  assign frame_done    = frame_done_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_adc_burst_framer.sv
// Scoreboard bench for adc_burst_framer with BURST_LEN = 4 and a
// behavioural capture-FIFO model that can drop a chosen read.
module tb_adc_burst_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] frame_bursts = 16'd0;
  logic        fifo_rd_en;
  logic [31:0] fifo_dout;
  logic        fifo_valid;
  logic [15:0] fifo_count = 16'd0;
  logic [15:0] sink_space = 16'd0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_hdr;
  logic        frame_done;
  logic        busy;
  logic        err_underflow;

  int checks = 0;
  int errors = 0;

  logic [31:0] fifo_q[$];
  logic [32:0] exp_q[$];
  int          drop_idx = -1;
  int          rd_idx;

  always #5 clk = ~clk;

  adc_burst_framer #(.BURST_LEN(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_bursts(frame_bursts),
    .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .fifo_valid(fifo_valid),
    .fifo_count(fifo_count), .sink_space(sink_space),
    .out_data(out_data), .out_valid(out_valid), .out_hdr(out_hdr),
    .frame_done(frame_done), .busy(busy), .err_underflow(err_underflow)
  );

  // Standard-mode FIFO: data/valid one cycle after rd_en.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_valid <= 1'b0;
      fifo_dout  <= 32'd0;
      rd_idx     <= 0;
    end else if (fifo_rd_en) begin
      logic [31:0] w;
      w = (fifo_q.size() > 0) ? fifo_q.pop_front() : 32'hDEADBEEF;
      rd_idx <= rd_idx + 1;
      if (rd_idx == drop_idx) begin
        fifo_valid <= 1'b0;
      end else begin
        fifo_valid <= 1'b1;
        fifo_dout  <= w;
      end
    end else begin
      fifo_valid <= 1'b0;
      rd_idx     <= 0;
    end
  end

  // Output scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream_extra: got hdr=%0b data=%08h, required no word", out_hdr, out_data);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({out_hdr, out_data} !== e) begin
          errors++;
          $display("FAIL stream_word: got hdr=%0b data=%08h, required hdr=%0b data=%08h",
                   out_hdr, out_data, e[32], e[31:0]);
        end else begin
          $display("word hdr=%0b data=%08h", out_hdr, out_data);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    fifo_count = 16'd0;
    sink_space = 16'd0;
    frame_bursts = 16'd0;
    drop_idx = -1;
    fifo_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_burst(input logic [31:0] hdr, input logic [31:0] base, input int drop);
    exp_q.push_back({1'b1, hdr});
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w;
      w = base + 32'h11 * (i + 1);
      fifo_q.push_back(w);
      if (i != drop) exp_q.push_back({1'b0, w});
    end
    drop_idx = drop;
  endtask

  // Triggers one burst in cycle 0 and records per-cycle signals for cycles 1..ncyc.
  task automatic run_burst(input int ncyc, input bit drop_en_c2, input int stop_cnt_c,
                           output logic [15:0] rd_m, output logic [15:0] vld_m,
                           output logic [15:0] fd_m, output logic [15:0] busy_m);
    rd_m = '0; vld_m = '0; fd_m = '0; busy_m = '0;
    enable = 1'b1;
    fifo_count = 16'd4;
    sink_space = 16'd5;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c == stop_cnt_c) fifo_count = 16'd0;
      if (c == 2 && drop_en_c2) enable = 1'b0;
      rd_m[c]   = fifo_rd_en;
      vld_m[c]  = out_valid;
      fd_m[c]   = frame_done;
      busy_m[c] = busy;
    end
    drop_idx = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if ({fifo_rd_en, out_valid, out_hdr, frame_done, busy, err_underflow, out_data} !== 38'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%0b v=%0b h=%0b fd=%0b busy=%0b err=%0b data=%08h, required all 0",
               fifo_rd_en, out_valid, out_hdr, frame_done, busy, err_underflow, out_data);
    end
    do_reset();
    checks++;
    if ({fifo_rd_en, out_valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: got rd=%0b v=%0b busy=%0b, required 0", fifo_rd_en, out_valid, busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [15:0] rd_m, vld_m, fd_m, busy_m;
    do_reset();
    push_burst(32'hA5000000, 32'h0, -1);
    run_burst(9, 1'b0, 1, rd_m, vld_m, fd_m, busy_m);
    checks++;
    if (rd_m !== 16'h001E) begin errors++; $display("FAIL single_rd_en: got %04h required %04h", rd_m, 16'h001E); end
    checks++;
    if (vld_m !== 16'h007C) begin errors++; $display("FAIL single_valid: got %04h required %04h", vld_m, 16'h007C); end
    checks++;
    if (busy_m !== 16'h003E) begin errors++; $display("FAIL single_busy: got %04h required %04h", busy_m, 16'h003E); end
    checks++;
    if (fd_m !== 16'h0080) begin errors++; $display("FAIL single_frame_done: got %04h required %04h", fd_m, 16'h0080); end
    $display("test_single done rd=%04h vld=%04h", rd_m, vld_m);
  endtask

  task automatic test_gating();
    logic saw;
    do_reset();
    enable = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      fifo_count = (pass == 0) ? 16'd3 : 16'd4;
      sink_space = (pass == 0) ? 16'd5 : 16'd4;
      saw = 1'b0;
      repeat (12) begin
        @(negedge clk);
        saw = saw | fifo_rd_en | busy;
      end
      checks++;
      if (saw !== 1'b0) begin
        errors++;
        $display("FAIL gating_pass%0d: got activity=%0b required 0", pass, saw);
      end
    end
    push_burst(32'hA5000000, 32'h100, -1);
    fifo_count = 16'd4;
    sink_space = 16'd5;
    @(negedge clk);
    fifo_count = 16'd0;
    checks++;
    if (fifo_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL gating_start: got rd_en=%0b required 1", fifo_rd_en);
    end
    repeat (9) @(negedge clk);
    $display("test_gating done");
  endtask

  task automatic test_frame();
    logic [15:0] rd_m, vld_m, fd_m, busy_m;
    logic [15:0] fd_req[3];
    logic [31:0] hdr[3];
    hdr[0] = 32'hA5000000; hdr[1] = 32'hA5000001; hdr[2] = 32'hA5010000;
    fd_req[0] = 16'h0000; fd_req[1] = 16'h0080; fd_req[2] = 16'h0000;
    do_reset();
    frame_bursts = 16'd2;
    for (int b = 0; b < 3; b++) begin
      push_burst(hdr[b], 32'h1000 * (b + 1), -1);
      run_burst(9, 1'b0, 1, rd_m, vld_m, fd_m, busy_m);
      checks++;
      if (fd_m !== fd_req[b]) begin
        errors++;
        $display("FAIL frame_done_b%0d: got %04h required %04h", b, fd_m, fd_req[b]);
      end
    end
    $display("test_frame done");
  endtask

  task automatic test_underflow();
    logic [15:0] rd_m, vld_m, fd_m, busy_m;
    do_reset();
    push_burst(32'hA5000000, 32'h200, 2);
    run_burst(9, 1'b0, 1, rd_m, vld_m, fd_m, busy_m);
    checks++;
    if (vld_m !== 16'h005C) begin errors++; $display("FAIL underflow_valid: got %04h required %04h", vld_m, 16'h005C); end
    checks++;
    if (err_underflow !== 1'b1) begin errors++; $display("FAIL underflow_flag: got %0b required 1", err_underflow); end
    push_burst(32'hA5010000, 32'h300, -1);
    run_burst(9, 1'b0, 1, rd_m, vld_m, fd_m, busy_m);
    checks++;
    if (vld_m !== 16'h007C) begin errors++; $display("FAIL underflow_next_valid: got %04h required %04h", vld_m, 16'h007C); end
    checks++;
    if (err_underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky: got %0b required 1", err_underflow); end
    $display("test_underflow done");
  endtask

  task automatic test_enable_drop();
    logic [15:0] rd_m, vld_m, fd_m, busy_m;
    logic saw;
    do_reset();
    push_burst(32'hA5000000, 32'h400, -1);
    run_burst(9, 1'b1, 0, rd_m, vld_m, fd_m, busy_m);
    checks++;
    if (vld_m !== 16'h007C) begin errors++; $display("FAIL enable_drop_valid: got %04h required %04h", vld_m, 16'h007C); end
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      saw = saw | fifo_rd_en;
    end
    checks++;
    if (saw !== 1'b0) begin errors++; $display("FAIL enable_drop_idle: got rd_en seen=%0b required 0", saw); end
    fifo_count = 16'd0;
    $display("test_enable_drop done");
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd_m, vld_m, fd_m, busy_m;
    do_reset();
    push_burst(32'hA5000000, 32'h500, -1);
    push_burst(32'hA5010000, 32'h600, -1);
    run_burst(14, 1'b0, 8, rd_m, vld_m, fd_m, busy_m);
    checks++;
    if (rd_m !== 16'h079E) begin errors++; $display("FAIL b2b_rd_en: got %04h required %04h", rd_m, 16'h079E); end
    checks++;
    if (vld_m !== 16'h1F7C) begin errors++; $display("FAIL b2b_valid: got %04h required %04h", vld_m, 16'h1F7C); end
    repeat (2) @(negedge clk);
    $display("test_back_to_back done");
  endtask

  task automatic test_frame_wrap();
    logic [15:0] rd_m, vld_m, fd_m, busy_m;
    logic [7:0]  f;
    do_reset();
    for (int i = 0; i <= 256; i++) begin
      f = i[7:0];
      push_burst({8'hA5, f, 16'h0000}, 32'h0, -1);
      run_burst(9, 1'b0, 1, rd_m, vld_m, fd_m, busy_m);
    end
    $display("test_frame_wrap done");
  endtask

  task automatic test_async_reset();
    do_reset();
    push_burst(32'hA5000000, 32'h700, -1);
    enable = 1'b1;
    fifo_count = 16'd4;
    sink_space = 16'd5;
    repeat (2) @(negedge clk);
    checks++;
    if ({fifo_rd_en, out_valid, busy} !== 3'b111) begin
      errors++;
      $display("FAIL arst_pre: got rd=%0b v=%0b busy=%0b required 1", fifo_rd_en, out_valid, busy);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({fifo_rd_en, out_valid, out_hdr, frame_done, busy, err_underflow, out_data} !== 38'd0) begin
      errors++;
      $display("FAIL arst_outputs: got rd=%0b v=%0b h=%0b fd=%0b busy=%0b err=%0b data=%08h, required all 0",
               fifo_rd_en, out_valid, out_hdr, frame_done, busy, err_underflow, out_data);
    end
    exp_q.delete();
    fifo_q.delete();
    enable = 1'b0;
    fifo_count = 16'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_gating();
    test_frame();
    test_underflow();
    test_enable_drop();
    test_back_to_back();
    test_frame_wrap();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_leftover: got %0d pending words, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
